nn_dense_layer_engine: RTL and testbench

//  Parametrised fully-connected layer for the MNIST accelerator: streams N_IN pixels, one per beat,

---
 rtl/nn_dense_layer_engine_if.sv | 36 +++
 rtl/nn_dense_layer_engine.sv | 150 +++++++++++++++
 tb/tb_nn_dense_layer_engine.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/nn_dense_layer_engine_if.sv
// rtl/nn_dense_layer_engine_if.sv - pixel/weight/bias/result signal bundle for the dense layer engine
interface nn_dense_layer_engine_if #(
  parameter int N_IN  = 64,
  parameter int N_OUT = 4,
  parameter int IN_W  = 1,
  parameter int WW    = 4,
  parameter int ACC_W = 12,
  parameter int OUT_W = 8
);
  localparam int AW = $clog2(N_IN);
  localparam int CW = $clog2(N_OUT);

  logic                   start;
  logic                   in_valid;
  logic                   in_ready;
  logic [IN_W-1:0]        in_pixel;
  logic [AW-1:0]          w_addr;
  logic [N_OUT*WW-1:0]    w_data;
  logic [N_OUT*ACC_W-1:0] b_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [N_OUT*OUT_W-1:0] out_data;
  logic [CW-1:0]          argmax;
  logic                   sat;
  logic                   busy;

  modport master (
    output start, in_valid, in_pixel, w_data, b_data, out_ready,
    input  in_ready, w_addr, out_valid, out_data, argmax, sat, busy
  );

  modport slave (
    input  start, in_valid, in_pixel, w_data, b_data, out_ready,
    output in_ready, w_addr, out_valid, out_data, argmax, sat, busy
  );
endinterface

// File: rtl/nn_dense_layer_engine.sv
// rtl/nn_dense_layer_engine.sv - streaming fully-connected layer with saturating MAC, clip and argmax
module nn_dense_layer_engine #(
  parameter int N_IN  = 64,
  parameter int N_OUT = 4,
  parameter int IN_W  = 1,
  parameter int WW    = 4,
  parameter int ACC_W = 12,
  parameter int OUT_W = 8,
  parameter int RELU  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  nn_dense_layer_engine_if.slave  bus
);
  localparam int AW = $clog2(N_IN);
  localparam int CW = $clog2(N_OUT);
  localparam int SW = ACC_W + 2;

  localparam logic signed [SW-1:0]    ACC_MAX  = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0]    ACC_MIN  = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] U_MAX    = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MAX    = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MIN    = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  // Flipping the MSB turns a signed comparison into an unsigned one.
  localparam logic [OUT_W-1:0]        KEY_FLIP = (RELU != 0) ? '0 : {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, HOLD} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc     [N_OUT];
  logic signed [ACC_W-1:0] acc_nxt [N_OUT];
  logic [N_OUT-1:0]        clamp;
  logic [AW-1:0]           cnt;
  logic                    accept, last_beat;
  logic [N_OUT*OUT_W-1:0]  clip_vec;
  logic [CW-1:0]           best_idx;
  logic [OUT_W-1:0]        best_key;
  logic                    out_valid_q, sat_q;
  logic [N_OUT*OUT_W-1:0]  out_data_q;
  logic [CW-1:0]           argmax_q;

  function automatic logic signed [ACC_W-1:0] sat_add(
    input  logic signed [ACC_W-1:0] a,
    input  logic [IN_W-1:0]         px,
    input  logic [WW-1:0]           w,
    output logic                    hit
  );
    logic signed [SW-1:0] px_ext, w_ext, sum;
    px_ext = {{(SW-IN_W){1'b0}}, px};
    w_ext  = {{(SW-WW){w[WW-1]}}, w};
    sum    = {{2{a[ACC_W-1]}}, a} + px_ext * w_ext;
    hit    = 1'b0;
    if (sum > ACC_MAX) begin
      hit = 1'b1;
      return ACC_MAX[ACC_W-1:0];
    end else if (sum < ACC_MIN) begin
      hit = 1'b1;
      return ACC_MIN[ACC_W-1:0];
    end
    return sum[ACC_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] clip(input logic signed [ACC_W-1:0] a);
    if (RELU != 0) begin
      if (a[ACC_W-1])  return '0;
      if (a > U_MAX)   return '1;
      return a[OUT_W-1:0];
    end
    if (a > S_MAX)     return S_MAX[OUT_W-1:0];
    if (a < S_MIN)     return S_MIN[OUT_W-1:0];
    return a[OUT_W-1:0];
  endfunction

  assign bus.in_ready  = ena && (state == ACCUM);
  assign bus.w_addr    = (state == ACCUM) ? cnt : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.argmax    = argmax_q;
  assign bus.sat       = sat_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_beat     = (cnt == AW'(N_IN - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)                    state_nxt = ACCUM;
      ACCUM:   if (accept && last_beat)          state_nxt = FINAL;
      FINAL:                                     state_nxt = HOLD;
      HOLD:    if (out_valid_q && bus.out_ready) state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_nxt = acc;
    clamp   = '0;
    for (int k = 0; k < N_OUT; k++)
      acc_nxt[k] = sat_add(acc[k], bus.in_pixel, bus.w_data[k*WW +: WW], clamp[k]);
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    clip_vec = '0;
    best_idx = '0;
    for (int k = 0; k < N_OUT; k++)
      clip_vec[k*OUT_W +: OUT_W] = clip(acc[k]);
    best_key = clip_vec[OUT_W-1:0] ^ KEY_FLIP;
    for (int k = 1; k < N_OUT; k++) begin
      if ((clip_vec[k*OUT_W +: OUT_W] ^ KEY_FLIP) > best_key) begin
        best_key = clip_vec[k*OUT_W +: OUT_W] ^ KEY_FLIP;
        best_idx = CW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      argmax_q    <= '0;
      sat_q       <= 1'b0;
      for (int k = 0; k < N_OUT; k++) acc[k] <= '0;
    end else if (ena) begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.start) begin
          for (int k = 0; k < N_OUT; k++) acc[k] <= bus.b_data[k*ACC_W +: ACC_W];
          cnt   <= '0;
          sat_q <= 1'b0;
        end
        ACCUM: if (accept) begin
          for (int k = 0; k < N_OUT; k++) acc[k] <= acc_nxt[k];
          sat_q <= sat_q | (|clamp);
          cnt   <= last_beat ? '0 : cnt + AW'(1);
        end
        FINAL: begin
          out_data_q  <= clip_vec;
          argmax_q    <= best_idx;
          out_valid_q <= 1'b1;
        end
        HOLD: if (bus.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nn_dense_layer_engine.sv
// tb/tb_nn_dense_layer_engine.sv - scoreboard bench for default, signed-clip and wide-pixel builds
module tb_nn_dense_layer_engine;
  logic clk = 1'b0;
  logic rst_n, ena;
  always #5 clk = ~clk;

  nn_dense_layer_engine_if #(.N_IN(64), .N_OUT(4), .IN_W(1), .WW(4), .ACC_W(12), .OUT_W(8)) a_if ();
  nn_dense_layer_engine_if #(.N_IN(64), .N_OUT(4), .IN_W(1), .WW(4), .ACC_W(12), .OUT_W(8)) b_if ();
  nn_dense_layer_engine_if #(.N_IN(16), .N_OUT(10), .IN_W(8), .WW(4), .ACC_W(12), .OUT_W(8)) c_if ();

  nn_dense_layer_engine #(.N_IN(64), .N_OUT(4), .IN_W(1), .WW(4), .ACC_W(12), .OUT_W(8), .RELU(1))
    u_a (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(a_if.slave));
  nn_dense_layer_engine #(.N_IN(64), .N_OUT(4), .IN_W(1), .WW(4), .ACC_W(12), .OUT_W(8), .RELU(0))
    u_b (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(b_if.slave));
  nn_dense_layer_engine #(.N_IN(16), .N_OUT(10), .IN_W(8), .WW(4), .ACC_W(12), .OUT_W(8), .RELU(1))
    u_c (.clk(clk), .rst_n(rst_n), .ena(ena), .bus(c_if.slave));

  typedef struct {
    logic [31:0] data;
    logic [1:0]  am;
    logic        sat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passed = 0;
  int          pix_a  [64];
  int          w_a    [64][4];
  int          bias_a [4];
  logic [15:0] wt_a   [64];
  logic [39:0] wc;

  assign a_if.w_data = wt_a[a_if.w_addr];
  assign b_if.w_data = 16'h1111;
  assign c_if.w_data = wc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load_a(input int pmode, input int wmode, input int b0, input int b1, input int b2, input int b3);
    bias_a[0] = b0; bias_a[1] = b1; bias_a[2] = b2; bias_a[3] = b3;
    for (int i = 0; i < 64; i++) begin
      pix_a[i] = (pmode < 0) ? int'($urandom_range(0, 1)) : pmode;
      for (int k = 0; k < 4; k++) begin
        w_a[i][k] = (wmode < -8) ? int'($urandom_range(0, 15)) - 8 : wmode;
        wt_a[i][k*4 +: 4] = w_a[i][k][3:0];
      end
    end
  endtask

  task automatic model_a();
    int acc, cl, best, bi;
    exp_t e;
    e.data = '0; e.sat = 1'b0; best = 0; bi = 0;
    for (int k = 0; k < 4; k++) begin
      acc = bias_a[k];
      for (int i = 0; i < 64; i++) begin
        acc += pix_a[i] * w_a[i][k];
        if (acc > 2047) begin acc = 2047; e.sat = 1'b1; end
        else if (acc < -2048) begin acc = -2048; e.sat = 1'b1; end
      end
      cl = (acc < 0) ? 0 : ((acc > 255) ? 255 : acc);
      e.data[k*8 +: 8] = cl[7:0];
      if (k == 0 || cl > best) begin best = cl; bi = k; end
    end
    e.am = bi[1:0];
    sb.push_back(e);
  endtask

  task automatic frame_a(input int bub, input bit ena_gap, input int hold);
    int   i, guard, lat;
    bit   acc_now;
    exp_t e;
    for (int k = 0; k < 4; k++) a_if.b_data[k*12 +: 12] = bias_a[k][11:0];
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    chk("a_busy_after_start", a_if.busy, 1);
    i = 0; guard = 0;
    while (i < 64 && guard < 2000) begin
      ena = !(ena_gap && $urandom_range(0, 9) == 0);
      a_if.in_valid = ($urandom_range(0, 99) >= bub);
      a_if.in_pixel = pix_a[i][0];
      #1;
      acc_now = ena && a_if.in_valid && a_if.in_ready;
      if (acc_now && (i == 0 || i == 37 || i == 63)) chk("a_w_addr", a_if.w_addr, i);
      @(posedge clk); #1;
      if (acc_now) i++;
      guard++;
    end
    ena = 1'b1;
    a_if.in_valid = 1'b0;
    chk("a_all_beats_accepted", i, 64);
    lat = 1;
    while (!a_if.out_valid && lat < 20) begin tick(); lat++; end
    chk("a_latency", lat, 2);
    chk("a_out_valid", a_if.out_valid, 1);
    if (sb.size() == 0) begin
      chk("a_scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("a_out_data", a_if.out_data, e.data);
      chk("a_argmax", a_if.argmax, e.am);
      chk("a_sat", a_if.sat, e.sat);
      for (int h = 0; h < hold; h++) begin
        a_if.out_ready = 1'b0;
        a_if.start = 1'b1;
        tick();
        chk("a_hold_valid", a_if.out_valid, 1);
        chk("a_hold_data", a_if.out_data, e.data);
        chk("a_hold_busy", a_if.busy, 1);
      end
      a_if.start = 1'b0;
      if (ena_gap) begin
        ena = 1'b0;
        a_if.out_ready = 1'b1;
        tick();
        chk("a_ena_low_hold", a_if.out_valid, 1);
        ena = 1'b1;
      end
    end
    a_if.out_ready = 1'b1;
    tick();
    a_if.out_ready = 1'b0;
    chk("a_release_valid", a_if.out_valid, 0);
    chk("a_release_busy", a_if.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; ena = 1'b1;
    a_if.start = 0; a_if.in_valid = 0; a_if.in_pixel = '0; a_if.b_data = '0; a_if.out_ready = 0;
    b_if.start = 0; b_if.in_valid = 0; b_if.in_pixel = '0; b_if.b_data = '0; b_if.out_ready = 0;
    c_if.start = 0; c_if.in_valid = 0; c_if.in_pixel = '0; c_if.b_data = '0; c_if.out_ready = 0;
    wc = '0;
    for (int k = 0; k < 10; k++) wc[k*4 +: 4] = 4'(k - 5);
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_out_valid", a_if.out_valid, 0);
    chk("rst_out_data", a_if.out_data, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_in_ready", a_if.in_ready, 0);
    chk("rst_w_addr", a_if.w_addr, 0);

    // basic frame: every neuron sums 64 and ties resolve to class 0
    load_a(1, 1, 0, 0, 0, 0);
    model_a();
    frame_a(0, 0, 0);

    load_a(0, 1, -5, 3, 3, 1);
    model_a();
    frame_a(0, 0, 0);

    load_a(1, -8, -2040, -2040, -2040, -2040);
    model_a();
    frame_a(0, 0, 0);
    load_a(1, 7, 2040, 2040, 2040, 2040);
    model_a();
    frame_a(0, 0, 0);

    // reset mid-frame after a saturated result: everything must clear
    a_if.start = 1'b1; tick(); a_if.start = 1'b0;
    a_if.in_valid = 1'b1;
    repeat (10) tick();
    a_if.in_valid = 1'b0;
    chk("mid_w_addr", a_if.w_addr, 10);
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    chk("mid_rst_busy", a_if.busy, 0);
    chk("mid_rst_out_data", a_if.out_data, 0);
    chk("mid_rst_sat", a_if.sat, 0);
    chk("mid_rst_in_ready", a_if.in_ready, 0);
    chk("mid_rst_out_valid", a_if.out_valid, 0);

    for (int r = 0; r < 3; r++) begin
      load_a(-1, -9, int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200,
             int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 400)) - 200);
      model_a();
      frame_a(30, 1, 5);
      model_a();
      frame_a(0, 0, 0);
    end

    b_if.b_data = {12'd1, 12'd3, 12'd3, 12'hffb};
    b_if.start = 1'b1; tick(); b_if.start = 1'b0;
    b_if.in_valid = 1'b1; b_if.in_pixel = 1'b0;
    repeat (64) tick();
    b_if.in_valid = 1'b0;
    n = 0;
    while (!b_if.out_valid && n < 20) begin tick(); n++; end
    chk("b_out_valid", b_if.out_valid, 1);
    chk("b_out_data", b_if.out_data, 32'h010303fb);
    chk("b_argmax", b_if.argmax, 1);
    chk("b_sat", b_if.sat, 0);
    b_if.out_ready = 1'b1; tick(); b_if.out_ready = 1'b0;
    chk("b_release", b_if.busy, 0);

    c_if.start = 1'b1; tick(); c_if.start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      c_if.in_valid = 1'b1;
      c_if.in_pixel = 8'(i);
      tick();
    end
    c_if.in_valid = 1'b0;
    n = 0;
    while (!c_if.out_valid && n < 20) begin tick(); n++; end
    chk("c_out_valid", c_if.out_valid, 1);
    chk("c_out_data", c_if.out_data, {8'hff, 8'hff, 8'hf0, 8'h78, 48'h0});
    // neurons 8 and 9 both clip to 255; the tie goes to 8
    chk("c_argmax", c_if.argmax, 8);
    chk("c_sat", c_if.sat, 0);
    c_if.out_ready = 1'b1; tick(); c_if.out_ready = 1'b0;
    chk("c_release", c_if.busy, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
